// File: rtl/edge_detector_multi_pkg.sv
// Shared encodings for the multi-channel edge detector.
package edge_det_pkg;

    // Selects which accepted edges drive the tick output.
    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_NONE = 2'b11
    } mode_t;

    // Per-channel edge FSM states.
    typedef enum logic [1:0] {
        ST_LOW       = 2'b00,
        ST_RISE_WAIT = 2'b01,
        ST_HIGH      = 2'b10,
        ST_FALL_WAIT = 2'b11
    } state_t;

    // Debounce counter width: clog2(d+1), never narrower than one bit.
    function automatic int cnt_width(input int d);
        return (d < 2) ? 1 : $clog2(d + 1);
    endfunction

endpackage

// File: rtl/edge_detector_multi_if.sv
// Control and event bus of the multi-channel edge detector.
interface edge_detector_multi_if #(
    parameter int CHANNELS = 4
);
    import edge_det_pkg::*;

    logic                en;
    mode_t               mode;
    logic                clear;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] stable_level;
    logic [CHANNELS-1:0] pending;
    logic                any_pending;

    // Consumer side: supplies raw levels and controls, receives events.
    modport master (
        output en, mode, clear, level,
        input  rise, fall, tick, stable_level, pending, any_pending
    );

    // Detector side.
    modport slave (
        input  en, mode, clear, level,
        output rise, fall, tick, stable_level, pending, any_pending
    );

endinterface

// File: rtl/edge_detector_multi_channel.sv
// One channel: synchroniser, debounce counter and Mealy edge FSM.
module edge_det_channel
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic level_i,
    output logic rise_o,
    output logic fall_o,
    output logic stable_o
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE > 0) ? DEBOUNCE - 1 : 0);

    logic             s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_ev, fall_ev;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = level_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            // Shift the raw level through the synchroniser chain.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= level_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Next state and Mealy edge events; any disagreeing sample aborts a wait.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_ev = 1'b0;
        fall_ev = 1'b0;
        unique case (state_q)
            ST_LOW: begin
                if (s) begin
                    if (DEBOUNCE == 0) begin
                        rise_ev = 1'b1;
                        state_d = ST_HIGH;
                    end else begin
                        state_d = ST_RISE_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RISE_WAIT: begin
                if (!s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    rise_ev = 1'b1;
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!s) begin
                    if (DEBOUNCE == 0) begin
                        fall_ev = 1'b1;
                        state_d = ST_LOW;
                    end else begin
                        state_d = ST_FALL_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            ST_FALL_WAIT: begin
                if (s) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    fall_ev = 1'b1;
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and debounce count; reset abandons any count in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Events are suppressed in the reset cycle and while disabled; the FSM keeps tracking.
    assign rise_o   = rise_ev & en_i & ~reset;
    assign fall_o   = fall_ev & en_i & ~reset;
    assign stable_o = (state_q == ST_HIGH) || (state_q == ST_FALL_WAIT);

endmodule

// File: rtl/edge_detector_multi.sv
// Multi-channel debounced edge detector with mode-selected ticks and sticky flags.
module edge_detector_multi
    import edge_det_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    edge_detector_multi_if.slave bus
);

    logic [CHANNELS-1:0] rise_w, fall_w, stable_w, tick_w;
    logic [CHANNELS-1:0] pending_q, pending_d;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        edge_det_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en_i     (bus.en),
            .level_i  (bus.level[gi]),
            .rise_o   (rise_w[gi]),
            .fall_o   (fall_w[gi]),
            .stable_o (stable_w[gi])
        );
    end

    // Mode selects which edges reach tick; applies in the same cycle.
    always_comb begin
        tick_w = '0;
        unique case (bus.mode)
            MODE_RISE: tick_w = rise_w;
            MODE_FALL: tick_w = fall_w;
            MODE_BOTH: tick_w = rise_w | fall_w;
            MODE_NONE: tick_w = '0;
            default:   tick_w = '0;
        endcase
    end

    // A tick in the same cycle as clear keeps its pending bit set.
    always_comb begin
        pending_d = tick_w | (pending_q & ~{CHANNELS{bus.clear}});
    end

    // Sticky pending flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign bus.rise         = rise_w;
    assign bus.fall         = fall_w;
    assign bus.tick         = tick_w;
    assign bus.stable_level = stable_w;
    assign bus.pending      = pending_q;
    assign bus.any_pending  = |pending_q;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Randomised bench for edge_detector_multi against a sliding-window reference model.
module tb_edge_detector_multi;
    import edge_det_pkg::*;

    localparam int CH = 4;
    localparam int SY = 2;
    localparam int DB = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    edge_detector_multi_if #(.CHANNELS(CH)) bus ();

    edge_detector_multi #(
        .CHANNELS    (CH),
        .SYNC_STAGES (SY),
        .DEBOUNCE    (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: raw-level delay line, recent synced samples, accepted level, sticky flag.
    bit pipe   [CH][SY+1];
    bit hist   [CH][DB+1];
    bit lvl_m  [CH];
    bit pend_m [CH];
    int n_rise_m   = 0;
    int n_rise_dut = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive on negedge, check, then advance the model across the posedge.
    task automatic step(input logic rst, input logic e, input logic [1:0] m,
                        input logic clr, input logic [CH-1:0] lv);
        logic [CH-1:0] r_m, f_m, t_m, st_m, p_m;
        bit s_now [CH];
        bit ev    [CH];
        @(negedge clk);
        reset     = rst;
        bus.en    = e;
        bus.mode  = mode_t'(m);
        bus.clear = clr;
        bus.level = lv;
        #1;
        for (int c = 0; c < CH; c++) begin
            bit run;
            s_now[c] = (SY == 0) ? lv[c] : pipe[c][(SY == 0) ? 0 : SY - 1];
            // An edge is accepted once the last DB+1 synced samples all differ from the accepted level.
            run = 1'b1;
            for (int j = 0; j < DB; j++) if (hist[c][j] != s_now[c]) run = 1'b0;
            ev[c]   = !rst && run && (s_now[c] != lvl_m[c]);
            r_m[c]  = ev[c] && s_now[c] && e;
            f_m[c]  = ev[c] && !s_now[c] && e;
            case (m)
                2'b00:   t_m[c] = r_m[c];
                2'b01:   t_m[c] = f_m[c];
                2'b10:   t_m[c] = r_m[c] | f_m[c];
                default: t_m[c] = 1'b0;
            endcase
            st_m[c] = lvl_m[c];
            p_m[c]  = pend_m[c];
        end
        chk("rise",         bus.rise,         r_m);
        chk("fall",         bus.fall,         f_m);
        chk("tick",         bus.tick,         t_m);
        chk("stable_level", bus.stable_level, st_m);
        chk("pending",      bus.pending,      p_m);
        chk("any_pending",  bus.any_pending,  |p_m);
        n_rise_m   += $countones(r_m);
        n_rise_dut += $countones(bus.rise);
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                for (int j = 0; j <= SY; j++) pipe[c][j] = 1'b0;
                for (int j = 0; j <= DB; j++) hist[c][j] = 1'b0;
                lvl_m[c]  = 1'b0;
                pend_m[c] = 1'b0;
            end else begin
                pend_m[c] = t_m[c] | (pend_m[c] & !clr);
                if (ev[c]) lvl_m[c] = s_now[c];
                for (int j = DB; j > 0; j--) hist[c][j] = hist[c][j-1];
                hist[c][0] = s_now[c];
                for (int j = SY; j > 0; j--) pipe[c][j] = pipe[c][j-1];
                pipe[c][0] = lv[c];
            end
        end
    endtask

    task automatic hold(input int n, input logic e, input logic [1:0] m,
                        input logic clr, input logic [CH-1:0] lv);
        for (int i = 0; i < n; i++) step(1'b0, e, m, clr, lv);
    endtask

    initial begin
        logic [CH-1:0] lv;
        logic [1:0]    m;
        logic          e;
        reset     = 1'b1;
        bus.en    = 1'b1;
        bus.mode  = MODE_RISE;
        bus.clear = 1'b0;
        bus.level = '0;

        // Reset with all levels low.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2'b00, 1'b0, 4'b0000);

        // Rising edge on channel 0.
        hold(12, 1'b1, 2'b00, 1'b0, 4'b0001);
        // Glitch on channel 1 (too short), then a long pulse.
        hold(3,  1'b1, 2'b00, 1'b0, 4'b0011);
        hold(6,  1'b1, 2'b00, 1'b0, 4'b0001);
        hold(8,  1'b1, 2'b00, 1'b0, 4'b0011);
        // Falling-only mode on channel 2.
        hold(8,  1'b1, 2'b01, 1'b0, 4'b0111);
        hold(8,  1'b1, 2'b01, 1'b0, 4'b0011);
        // Disabled while channel 3 rises, then re-enabled.
        hold(8,  1'b0, 2'b00, 1'b0, 4'b1011);
        hold(6,  1'b1, 2'b00, 1'b0, 4'b1011);
        // All channels toggling together in both-edges mode.
        hold(8,  1'b1, 2'b10, 1'b0, 4'b0000);
        hold(8,  1'b1, 2'b10, 1'b0, 4'b1111);
        hold(8,  1'b1, 2'b10, 1'b0, 4'b0000);
        // Clear held across a tick, then released.
        hold(8,  1'b1, 2'b10, 1'b1, 4'b0001);
        hold(3,  1'b1, 2'b10, 1'b0, 4'b0001);
        hold(8,  1'b1, 2'b10, 1'b1, 4'b0000);
        // Reset in the middle of a debounce wait, level dropped with it.
        hold(4,  1'b1, 2'b00, 1'b0, 4'b0010);
        step(1'b1, 1'b1, 2'b00, 1'b0, 4'b0000);
        hold(8,  1'b1, 2'b00, 1'b0, 4'b0000);
        // Level already high when reset releases yields one rise.
        step(1'b1, 1'b1, 2'b00, 1'b0, 4'b0100);
        hold(10, 1'b1, 2'b00, 1'b0, 4'b0100);

        // Random traffic: mix of glitches and held levels, control noise.
        lv = 4'b0100;
        m  = 2'b10;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < CH; c++) if ($urandom_range(5) == 0) lv[c] = ~lv[c];
            if ($urandom_range(15) == 0) m = 2'($urandom_range(3));
            e = ($urandom_range(9) != 0);
            step($urandom_range(99) == 0, e, m, $urandom_range(9) == 0, lv);
        end

        chk("rise_count", n_rise_dut, n_rise_m);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_detector_multi.md
Name: edge_detector_multi

Overview:
- Multi-channel, parametrised successor to the single-bit Mealy level-to-tick edge detector.
- Each channel has an input synchroniser, a debounce/glitch filter and a 4-state Mealy edge FSM.
- Produces one-cycle rise/fall ticks, a mode-selected event tick, and sticky pending flags.
- Sits between raw asynchronous pins (buttons, status lines) and control FSMs that consume single-cycle events.

Parameters:
- CHANNELS, 4: number of independent input channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per channel (0..3; 0 means the input is already synchronous).
- DEBOUNCE, 3: extra consecutive stable synced samples required before an edge is accepted (0..255; 0 means no filtering).

Ports:
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  1 = ticks enabled; 0 = all tick outputs forced to 0 while the FSMs keep tracking.
- mode  in  2  00 rising, 01 falling, 10 both edges, 11 none; selects the `tick` source.
- clear  in  1  synchronous clear of all `pending` bits.
- level  in  CHANNELS  raw level inputs, one bit per channel.
- rise  out  CHANNELS  one-cycle pulse on an accepted rising edge (masked by en only).
- fall  out  CHANNELS  one-cycle pulse on an accepted falling edge (masked by en only).
- tick  out  CHANNELS  rise/fall filtered by mode and en.
- stable_level  out  CHANNELS  debounced level.
- pending  out  CHANNELS  sticky: set by tick, cleared by clear.
- any_pending  out  1  OR-reduction of `pending`.

Behaviour:
- Reset is synchronous. On reset:
  - sync flops = 0, FSM = LOW, counters = 0, pending = 0.
  - rise, fall, tick are 0 in the reset cycle; stable_level = 0; any_pending = 0.
- A level that is high when reset is released produces exactly one rising event after the normal latency.
- Per-channel FSM states: LOW, RISE_WAIT, HIGH, FALL_WAIT. `s` is the synced level; `D` is DEBOUNCE.
  - LOW: if s=1 and D=0, rise pulses this cycle (Mealy) and next state is HIGH. If s=1 and D>0, go to RISE_WAIT with cnt=0. Otherwise stay.
  - RISE_WAIT: if s=0, return to LOW with no event. Else if cnt==D-1, rise pulses this cycle and next state is HIGH. Else cnt++.
  - HIGH and FALL_WAIT: mirror images of LOW and RISE_WAIT, producing fall.
- rise and fall are combinational from state, cnt, s and en. Each is high for exactly one cycle per accepted edge and never both at once on one channel.
- Latency: a level change applied after clock edge k gives s changed after edge k+SYNC_STAGES. The event pulse occurs in the cycle after edge k+SYNC_STAGES+D.
- The input must be stable for D+1 consecutive synced samples. Shorter pulses are fully rejected with no event.
- stable_level = 1 in HIGH and FALL_WAIT; it changes on the edge following the rise/fall pulse.
- `tick[i]` by mode:
  - 00: rise[i]
  - 01: fall[i]
  - 10: rise[i] | fall[i]
  - 11: 0
- mode changes take effect combinationally in the same cycle.
- en=0: the FSMs still advance, so no stale event fires on re-enable. Edges accepted while en=0 are lost.
- pending[i]:
  - set on the next edge after tick[i];
  - cleared on the next edge after clear;
  - set wins over clear when both occur in the same cycle.
- any_pending is combinational from the pending register.
- Reset mid-debounce aborts the count; no event is produced.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- Counter width is clog2(DEBOUNCE+1), minimum 1.

Decomposition:
- Shared package `edge_det_pkg`:
  - mode encodings: MODE_RISE, MODE_FALL, MODE_BOTH, MODE_NONE;
  - FSM state encoding (2-bit): ST_LOW, ST_RISE_WAIT, ST_HIGH, ST_FALL_WAIT.
- One sub-module, `edge_det_channel`, containing the synchroniser, debounce counter, FSM and rise/fall/stable outputs. The top instantiates it CHANNELS times in a generate loop.
- The top level holds the mode/en masking, the pending register and the any_pending reduction.

Test Plan (defaults CHANNELS=4, SYNC_STAGES=2, DEBOUNCE=3; stimulus applied on negedge):
- Reset with level=0 held for 5 cycles -> all outputs 0 throughout.
- Rising edge, mode=00: level[0] 0->1 after edge k, held 10 cycles -> rise[0]=tick[0]=1 only in the cycle after edge k+5; stable_level[0] and pending[0] =1 from edge k+6; other channels stay 0.
- Glitch rejection: level[1] high for 3 cycles then low -> no rise, no tick, and stable_level[1] stays 0. Then hold high 4+ cycles -> one rise is accepted.
- Falling-only mode: mode=01, level[2] high for 8 cycles then low -> rise[2] pulses but tick[2]=0 on the rise; tick[2] and fall[2] pulse in the cycle after fall-edge+5.
- Enable and both-edges mode:
  - en=0 while level[3] rises -> no rise/tick, stable_level[3]=1; en later set to 1 -> still no tick.
  - mode=10 with 4 channels toggling simultaneously -> 4 concurrent ticks per edge.
- Sticky flag and reset abort:
  - clear asserted in the same cycle as tick[0] -> pending[0] stays 1; clear alone next cycle -> pending[0]=0, any_pending=0.
  - reset asserted during RISE_WAIT -> no event, all outputs 0.
